// File: rtl/bsort_pkg.sv
// ---------------------------------------------------------------------------
// bsort_pkg
// Shared types and sizing helpers for the bit-serial bubble-sort pass
// sequencer.
//   state_t      : sequencer states
//   DEF_*        : default network configuration
//   BIT_CNT_W    : width of the run-window bit counter, $clog2(WIDTH)
//   PASS_CNT_W   : width of the pass counter, $clog2(N)+1
//   WDOG_W       : width of the watchdog counter
//   bits_for()   : bits needed to hold the values 0..max_val
// ---------------------------------------------------------------------------
package bsort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    GAP,
    DONE
  } state_t;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_N          = 4;
  localparam int DEF_NET_LAT    = 6;
  localparam int DEF_GAP_CYCLES = 2;

  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int BIT_CNT_W  = bits_for(DEF_WIDTH - 1);
  localparam int PASS_CNT_W = $clog2(DEF_N) + 1;
  localparam int WDOG_W     = bits_for(DEF_WIDTH + DEF_NET_LAT + 2);

endpackage

// File: rtl/bsort_pass_ctrl.sv
// ---------------------------------------------------------------------------
// bsort_pass_ctrl
// Pass sequencer for the bit-serial bubble-sort network. Loads the network
// source registers, streams WIDTH bits MSB-first with the run flag high,
// waits for the run flag to leave the chain tail, and repeats passes on the
// captured results until a pass sees no swap or MAX_PASSES is reached.
//
// Ports:
//   clk, rst        clock / asynchronous active-high reset
//   start_i         begin a sort (accepted in IDLE only)
//   busy_o          sort in progress (low again in the done_o cycle)
//   done_o          one-cycle completion pulse
//   error_o         one-cycle pulse with done_o when the watchdog fires
//   pass_cnt_o      passes completed in the current/last sort
//   swapped_o       swap seen in the most recent completed pass
//   net_load_o      parallel load of the network source registers
//   net_src_o       load source: 0 external words, 1 captured results
//   net_shift_o     shift the source registers one bit
//   net_run_o       run flag into the first cell
//   net_swap_o      swap flag into the first cell (always 0)
//   net_capture_o   capture the tail output bits this cycle
//   net_run_i       run flag from the chain tail
//   net_swap_i      swap flag from the chain tail
// ---------------------------------------------------------------------------
module bsort_pass_ctrl
  import bsort_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int N          = DEF_N,
  parameter int NET_LAT    = DEF_NET_LAT,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int MAX_PASSES = N - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [$clog2(N):0] pass_cnt_o,
  output logic              swapped_o,
  output logic              net_load_o,
  output logic              net_src_o,
  output logic              net_shift_o,
  output logic              net_run_o,
  output logic              net_swap_o,
  output logic              net_capture_o,
  input  logic              net_run_i,
  input  logic              net_swap_i
);

  localparam int BIT_W      = bits_for(WIDTH - 1);
  localparam int PASS_W     = $clog2(N) + 1;
  localparam int WDOG_LIMIT = WIDTH + NET_LAT + 2;
  localparam int WDOG_CW    = bits_for(WDOG_LIMIT);
  localparam int GAP_W      = bits_for(GAP_CYCLES - 1);

  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [WDOG_CW-1:0] WDOG_LAST = WDOG_CW'(WDOG_LIMIT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PASS_W-1:0]  PASS_MAX  = PASS_W'(MAX_PASSES);

  state_t             state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WDOG_CW-1:0] wdog_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               pass_swap;
  logic               run_prev;
  logic               in_window;
  logic               run_fall;

  // The tail is only listened to while a pass is in flight; stray run/swap
  // flags in any other state are ignored.
  assign in_window     = (state == RUN) || (state == DRAIN);
  assign run_fall      = run_prev & ~net_run_i;
  assign net_capture_o = in_window & net_run_i;
  assign net_swap_o    = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      wdog_cnt    <= '0;
      gap_cnt     <= '0;
      pass_swap   <= 1'b0;
      run_prev    <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      pass_cnt_o  <= '0;
      swapped_o   <= 1'b0;
      net_load_o  <= 1'b0;
      net_src_o   <= 1'b0;
      net_shift_o <= 1'b0;
      net_run_o   <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      net_load_o <= 1'b0;
      // Gated so the falling-edge detector starts clean on every pass.
      run_prev   <= in_window & net_run_i;
      if (in_window && net_run_i && net_swap_i) begin
        pass_swap <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            state      <= LOAD;
            busy_o     <= 1'b1;
            pass_cnt_o <= '0;
            net_load_o <= 1'b1;
            net_src_o  <= 1'b0;
          end
        end

        LOAD: begin
          state       <= RUN;
          pass_swap   <= 1'b0;
          bit_cnt     <= '0;
          wdog_cnt    <= '0;
          net_run_o   <= 1'b1;
          net_shift_o <= 1'b1;
        end

        RUN: begin
          bit_cnt  <= bit_cnt + 1'b1;
          wdog_cnt <= wdog_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state       <= DRAIN;
            net_run_o   <= 1'b0;
            net_shift_o <= 1'b0;
          end
        end

        // The watchdog counts from RUN entry, so it can only expire here;
        // a falling edge in the same cycle still wins.
        DRAIN: begin
          wdog_cnt <= wdog_cnt + 1'b1;
          if (run_fall) begin
            state      <= GAP;
            gap_cnt    <= '0;
            pass_cnt_o <= pass_cnt_o + 1'b1;
            swapped_o  <= pass_swap;
          end else if (wdog_cnt == WDOG_LAST) begin
            state   <= DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            error_o <= 1'b1;
          end
        end

        // pass_cnt_o already includes the pass that just drained.
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GAP_LAST) begin
            if (!pass_swap || (pass_cnt_o == PASS_MAX)) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              state      <= LOAD;
              net_load_o <= 1'b1;
              net_src_o  <= 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsort_pass_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bsort_pass_ctrl
// Bench for the bubble-sort pass sequencer. A behavioural network (run flag
// delayed by NET_LAT, one bubble pass per load) answers the DUT strobes; a
// reference model pushes the expected sort outcome into a queue and a
// monitor pops it on every done_o.
// ---------------------------------------------------------------------------
module tb_bsort_pass_ctrl;

  localparam int WIDTH      = 8;
  localparam int N          = 4;
  localparam int NET_LAT    = 6;
  localparam int GAP_CYCLES = 2;
  localparam int MAX_PASSES = N - 1;
  localparam int PASS_W     = $clog2(N) + 1;

  typedef logic [N-1:0][WIDTH-1:0] words_t;

  typedef struct packed {
    logic        timeout;
    logic [7:0]  passes;
    logic        swapped;
    logic [15:0] latency;
    words_t      words;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start_i;
  logic              busy_o;
  logic              done_o;
  logic              error_o;
  logic [PASS_W-1:0] pass_cnt_o;
  logic              swapped_o;
  logic              net_load_o;
  logic              net_src_o;
  logic              net_shift_o;
  logic              net_run_o;
  logic              net_swap_o;
  logic              net_capture_o;
  logic              net_run_i;
  logic              net_swap_i;

  int     checks = 0;
  int     fails  = 0;
  int     cycle  = 0;
  exp_t   expQ[$];
  bit     lastSwap = 0;

  // behavioural network state
  words_t extWords = '0;
  words_t capWords = '0;
  words_t resWords = '0;
  bit     passSwap = 0;
  bit     stuckRun = 0;
  int     swapBit  = 0;
  int     tailPos  = 0;
  int     capBit   = 0;

  // per-sort observations
  int     loadCycle   = 0;
  int     runCnt      = 0;
  int     capCnt      = 0;
  int     srcOneLoads = 0;

  bsort_pass_ctrl #(
    .WIDTH(WIDTH), .N(N), .NET_LAT(NET_LAT),
    .GAP_CYCLES(GAP_CYCLES), .MAX_PASSES(MAX_PASSES)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .pass_cnt_o(pass_cnt_o), .swapped_o(swapped_o),
    .net_load_o(net_load_o), .net_src_o(net_src_o),
    .net_shift_o(net_shift_o), .net_run_o(net_run_o),
    .net_swap_o(net_swap_o), .net_capture_o(net_capture_o),
    .net_run_i(net_run_i), .net_swap_i(net_swap_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One ascending bubble pass: larger words move toward the higher index.
  function automatic words_t bubblePass(input words_t src, output bit sw);
    words_t     w;
    logic [WIDTH-1:0] t;
    w  = src;
    sw = 1'b0;
    for (int j = 0; j < N - 1; j++) begin
      if (w[j] > w[j+1]) begin
        t      = w[j];
        w[j]   = w[j+1];
        w[j+1] = t;
        sw     = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic words_t mk(input int a, input int b, input int c, input int d);
    words_t w;
    w[0] = a[WIDTH-1:0];
    w[1] = b[WIDTH-1:0];
    w[2] = c[WIDTH-1:0];
    w[3] = d[WIDTH-1:0];
    return w;
  endfunction

  // Network tail: run flag delayed NET_LAT cycles; swap flag raised on one
  // random bit of the window when the pass swapped, random noise otherwise.
  initial begin
    bit runHist[$];
    bit tailRun;
    net_run_i  = 1'b0;
    net_swap_i = 1'b0;
    for (int i = 0; i < NET_LAT; i++) runHist.push_back(1'b0);
    forever begin
      @(posedge clk);
      #1;
      runHist.push_back(net_run_o);
      tailRun   = runHist.pop_front();
      net_run_i = stuckRun ? 1'b0 : tailRun;
      if (net_run_i) begin
        net_swap_i = passSwap && (tailPos == swapBit);
        tailPos++;
      end else begin
        net_swap_i = 1'($urandom_range(0, 1));
        tailPos    = 0;
      end
    end
  end

  // Network data model plus scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (net_load_o) begin
        if (!net_src_o) begin
          loadCycle   = cycle;
          runCnt      = 0;
          capCnt      = 0;
          srcOneLoads = 0;
        end else begin
          srcOneLoads++;
        end
        resWords = bubblePass(net_src_o ? capWords : extWords, passSwap);
        swapBit  = $urandom_range(0, WIDTH - 1);
        capBit   = WIDTH - 1;
      end
      if (net_run_o) runCnt++;
      if (net_capture_o) begin
        if (capBit >= 0) begin
          for (int i = 0; i < N; i++) capWords[i][capBit] = resWords[i][capBit];
          capBit--;
        end
        capCnt++;
      end
      if (net_run_i && !busy_o) checkOutput("capture_outside_sort", net_capture_o, 0);
      if (done_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_done", done_o, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("error_o", error_o, e.timeout);
          checkOutput("pass_cnt_o", pass_cnt_o, e.passes);
          checkOutput("swapped_o", swapped_o, e.swapped);
          checkOutput("busy_at_done", busy_o, 0);
          checkOutput("load_to_done", cycle - loadCycle, e.latency);
          checkOutput("run_cycles", runCnt, e.timeout ? WIDTH : WIDTH * e.passes);
          checkOutput("capture_cycles", capCnt, e.timeout ? 0 : WIDTH * e.passes);
          checkOutput("recirc_loads", srcOneLoads, e.timeout ? 0 : e.passes - 1);
          if (!e.timeout) checkOutput("captured_words", capWords, e.words);
        end
      end
    end
  end

  task automatic applyStimulus(input words_t w, input bit stuck,
                               input bit pulseRun, input bit pulseDone);
    exp_t   e;
    words_t m;
    bit     sw;
    int     p;
    bit     pulsed;
    bit     seen;
    extWords = w;
    stuckRun = stuck;
    e = '0;
    if (stuck) begin
      e.timeout = 1'b1;
      e.passes  = 8'd0;
      e.swapped = lastSwap;
      e.latency = 16'(1 + WIDTH + NET_LAT + 2);
      e.words   = w;
    end else begin
      m = w;
      p = 0;
      do begin
        m = bubblePass(m, sw);
        p++;
      end while (sw && p < MAX_PASSES);
      e.passes  = 8'(p);
      e.swapped = sw;
      e.latency = 16'(p * (1 + WIDTH + NET_LAT + 1 + GAP_CYCLES));
      e.words   = m;
      lastSwap  = sw;
    end
    expQ.push_back(e);
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    pulsed = 0;
    seen   = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) begin
        seen = 1;
        if (pulseDone) start_i = 1'b1;
      end else if (pulseRun && !pulsed && net_run_o) begin
        start_i = 1'b1;
        pulsed  = 1;
      end
    end
    checkOutput("done_seen", seen, 1);
    @(negedge clk);
    start_i = 1'b0;
    if (pulseDone) begin
      repeat (24) @(negedge clk);
      checkOutput("idle_after_done_start", busy_o, 0);
    end
    stuckRun = 1'b0;
  endtask

  task automatic resetMidRun(input words_t w);
    bit found;
    extWords = w;
    stuckRun = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (net_run_o) found = 1;
    end
    checkOutput("rst_run_seen", found, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_net_run_o", net_run_o, 0);
    checkOutput("rst_net_shift_o", net_shift_o, 0);
    checkOutput("rst_busy_o", busy_o, 0);
    checkOutput("rst_done_o", done_o, 0);
    @(negedge clk);
    rst = 1'b0;
    lastSwap = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("post_rst_busy", busy_o, 0);
    checkOutput("post_rst_swapped", swapped_o, 0);
    checkOutput("post_rst_pass_cnt", pass_cnt_o, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    words_t w;
    rst     = 1'b1;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_error", error_o, 0);
    checkOutput("reset_pass_cnt", pass_cnt_o, 0);
    checkOutput("reset_swapped", swapped_o, 0);
    checkOutput("reset_net_strobes",
                {net_load_o, net_src_o, net_shift_o, net_run_o, net_swap_o}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] sorted input");
    applyStimulus(mk(1, 2, 3, 4), 0, 0, 0);
    $display("[TB] reversed input");
    applyStimulus(mk(4, 3, 2, 1), 0, 0, 0);
    $display("[TB] all equal input");
    applyStimulus(mk(8'h55, 8'h55, 8'h55, 8'h55), 0, 0, 0);
    $display("[TB] tail run flag stuck low");
    applyStimulus(mk(9, 7, 5, 3), 1, 0, 0);
    $display("[TB] reset during RUN");
    resetMidRun(mk(4, 3, 2, 1));
    applyStimulus(mk(2, 1, 4, 3), 0, 0, 0);
    $display("[TB] start pulses during RUN and DONE");
    applyStimulus(mk(4, 3, 2, 1), 0, 1, 1);

    $display("[TB] randomized sorts");
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) w[i] = WIDTH'($urandom_range(0, 255));
      applyStimulus(w, 0, 1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
